// File: rtl/tb_uart_rx_monitor.sv
// Bench-side UART receiver: oversamples rx_i and deserialises 8N1 frames.
// Received bytes go into a fall-through FIFO that drains over a valid/ready port.
// Optional even parity (8E1) is enabled by defining TB_UART_RX_PARITY_EN.
module tb_uart_rx_monitor #(
  parameter int unsigned ClksPerBit = 16,
  parameter int unsigned FifoDepth  = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               rx_i,
  output logic [7:0]                         data_o,
  output logic                               valid_o,
  input  logic                               ready_i,
  output logic [$clog2(FifoDepth+1)-1:0]     count_o,
  output logic                               frame_err_o,
  output logic                               parity_err_o,
  output logic                               overflow_o
);

  localparam int unsigned CntW   = $clog2(ClksPerBit);
  localparam int unsigned PtrW   = $clog2(FifoDepth);
  localparam int unsigned CountW = $clog2(FifoDepth + 1);

  localparam logic [CntW-1:0]   CntLast   = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0]   CntMid    = CntW'(ClksPerBit / 2 - 1);
  localparam logic [CountW-1:0] CountFull = CountW'(FifoDepth);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } state_e;

  logic            rx_meta_q, rx_s_q;
  state_e          state_q;
  logic [CntW-1:0] bit_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            par_bad_q;
  logic            frame_err_q;

  logic [7:0]        mem_q [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CountW-1:0] count_q;
  logic              overflow_q;

  logic stop_sample, push, pop, full, push_ok;

  // The byte is only offered on a clean stop bit of a frame with good parity.
  assign stop_sample = (state_q == StStop) && (bit_cnt_q == CntLast);
  assign push        = stop_sample && rx_s_q && !par_bad_q;
  assign full        = (count_q == CountFull);
  assign pop         = valid_o && ready_i;
  assign push_ok     = push && (!full || pop);

  // Two-flop synchroniser; reset to idle-high so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

`ifdef TB_UART_RX_PARITY_EN
  logic parity_err_q;
`endif

  // Frame FSM: bit timing, deserialisation and registered error pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef TB_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q <= 1'b0;
`ifdef TB_UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      // Free-running bit counter; ClksPerBit need not be a power of two.
      if (bit_cnt_q == CntLast) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + CntW'(1);
      end
      unique case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          par_bad_q <= 1'b0;
          if (!rx_s_q) begin
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_cnt_q == CntMid) begin
            bit_cnt_q <= '0;
            if (!rx_s_q) begin
              state_q   <= StData;
              bit_idx_q <= '0;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StData: begin
          if (bit_cnt_q == CntLast) begin
            shift_q   <= {rx_s_q, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
`ifdef TB_UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef TB_UART_RX_PARITY_EN
        StParity: begin
          if (bit_cnt_q == CntLast) begin
            // Even parity: data bits plus parity bit must XOR to zero.
            if (rx_s_q != ^shift_q) begin
              par_bad_q    <= 1'b1;
              parity_err_q <= 1'b1;
            end
            state_q <= StStop;
          end
        end
`endif
        StStop: begin
          if (bit_cnt_q == CntLast) begin
            if (rx_s_q) begin
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end
          end
        end
        StBreak: begin
          // Held-low line: wait for idle so it reports only one frame error.
          bit_cnt_q <= '0;
          if (rx_s_q) begin
            state_q <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end else if (push) begin
        overflow_q <= 1'b1;
      end
      if (push_ok && !pop) begin
        count_q <= count_q + CountW'(1);
      end else if (!push_ok && pop) begin
        count_q <= count_q - CountW'(1);
      end
    end
  end

  // FIFO storage; when full with a pop, the written slot is the one being freed.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign valid_o     = (count_q != '0);
  assign data_o      = valid_o ? mem_q[rd_ptr_q] : 8'h00;
  assign count_o     = count_q;
  assign frame_err_o = frame_err_q;
  assign overflow_o  = overflow_q;
`ifdef TB_UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_tb_uart_rx_monitor.sv
// Self-checking bench for tb_uart_rx_monitor: directed scenarios plus randomized
// frames, compared every cycle against a queue-based model of the byte stream.
module tb_tb_uart_rx_monitor;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef TB_UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Edges from the line's falling edge to the stop-bit sample: 2 sync + 1 detect,
  // half a bit to mid start, then one bit per data (and parity) bit plus stop.
  localparam int LAT = 3 + CPB / 2 + CPB * NBITS;

  logic          clk, rst, rx, ready;
  logic [7:0]    data;
  logic          valid, ferr, perr, ovf;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int ready_pct = 100;
  bit rnd_done = 0;

  logic [7:0] model_q[$];
  logic [7:0] pop_log[$];
  int         sp_cyc[$];
  logic [7:0] sp_dat[$];
  int         sf_cyc[$];
  int         spe_cyc[$];
  bit         m_ovf = 0;
  bit         exp_ferr = 0;
  bit         exp_perr = 0;

  tb_uart_rx_monitor #(
    .ClksPerBit(CPB),
    .FifoDepth (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rx_i        (rx),
    .data_o      (data),
    .valid_o     (valid),
    .ready_i     (ready),
    .count_o     (count),
    .frame_err_o (ferr),
    .parity_err_o(perr),
    .overflow_o  (ovf)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model of the byte stream: scheduled pushes/errors applied at their edges.
  always @(posedge clk) begin
    bit pop, push, full_before;
    logic [7:0] pb;
    cyc++;
    exp_ferr = 0;
    exp_perr = 0;
    if (rst) begin
      model_q.delete();
      sp_cyc.delete();
      sp_dat.delete();
      sf_cyc.delete();
      spe_cyc.delete();
      m_ovf = 0;
    end else begin
      push = 0;
      pb = 8'h00;
      while (sp_cyc.size() > 0 && sp_cyc[0] <= cyc) begin
        if (sp_cyc[0] == cyc) begin
          push = 1;
          pb = sp_dat[0];
        end
        void'(sp_cyc.pop_front());
        void'(sp_dat.pop_front());
      end
      while (sf_cyc.size() > 0 && sf_cyc[0] <= cyc) begin
        if (sf_cyc[0] == cyc) exp_ferr = 1;
        void'(sf_cyc.pop_front());
      end
      while (spe_cyc.size() > 0 && spe_cyc[0] <= cyc) begin
        if (spe_cyc[0] == cyc) exp_perr = 1;
        void'(spe_cyc.pop_front());
      end
      full_before = (model_q.size() == DEPTH);
      pop = (model_q.size() > 0) && ready;
      if (pop) void'(model_q.pop_front());
      if (push) begin
        if (!full_before || pop) model_q.push_back(pb);
        else m_ovf = 1;
      end
    end
  end

  // Handshake log and error pulse counters.
  always @(posedge clk) begin
    if (!rst && valid && ready) pop_log.push_back(data);
  end

  always @(negedge clk) begin
    if (ferr === 1'b1) ferr_cnt++;
    if (perr === 1'b1) perr_cnt++;
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", valid, model_q.size() != 0);
      check("count", count, model_q.size());
      if (model_q.size() > 0) check("data", data, model_q[0]);
      check("overflow", ovf, m_ovf);
      check("frame_err", ferr, exp_ferr);
      check("parity_err", perr, exp_perr);
    end
  end

  // Drives one frame starting at the current negedge and schedules its effects.
  task automatic drive_frame(input logic [7:0] b, input bit par_ok, input bit stop_ok,
                             input int extra_low);
    int e0;
    e0 = cyc;
    if (stop_ok && par_ok) begin
      sp_cyc.push_back(e0 + LAT);
      sp_dat.push_back(b);
    end
    if (!stop_ok) sf_cyc.push_back(e0 + LAT);
`ifdef TB_UART_RX_PARITY_EN
    if (!par_ok) spe_cyc.push_back(e0 + LAT - CPB);
`endif
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef TB_UART_RX_PARITY_EN
    rx = par_ok ? ^b : ~^b;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop_ok;
    repeat (CPB) @(negedge clk);
    if (!stop_ok) begin
      repeat (extra_low) @(negedge clk);
      rx = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic glitch(input int len);
    rx = 1'b0;
    repeat (len) @(negedge clk);
    rx = 1'b1;
  endtask

  initial begin
    int f0, p0, e0, k;
    rx = 1'b1;
    ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_valid", valid, 0);
    check("rst_count", count, 0);
    check("rst_overflow", ovf, 0);
    check("rst_frame_err", ferr, 0);
    check("rst_data", data, 0);
    chk_en = 1;

    // Single byte with consumer ready
    ready = 1'b1;
    f0 = ferr_cnt;
    pop_log.delete();
    drive_frame(8'hA5, 1, 1, 0);
    idle(4);
    check("t2_pops", pop_log.size(), 1);
    if (pop_log.size() > 0) check("t2_data", pop_log[0], 8'hA5);
    check("t2_ferr", ferr_cnt - f0, 0);

    // Short low glitch rejected
    glitch(4);
    idle(20);
    check("t3_count", count, 0);
    check("t3_pops", pop_log.size(), 1);
    check("t3_ferr", ferr_cnt - f0, 0);

    // Bad stop bit then held-low line
    f0 = ferr_cnt;
    drive_frame(8'h3C, 1, 0, 100);
    idle(10);
    check("t4_ferr_pulses", ferr_cnt - f0, 1);
    check("t4_count", count, 0);

    // Overflow with consumer stalled, then in-order drain
    ready = 1'b0;
    for (int i = 0; i < 9; i++) drive_frame(8'(i), 1, 1, 0);
    idle(5);
    check("t5_count", count, 8);
    check("t5_overflow", ovf, 1);
    pop_log.delete();
    ready = 1'b1;
    idle(12);
    ready = 1'b0;
    check("t5_drained", pop_log.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_log.size()) check("t5_order", pop_log[i], i);
    end

    // Full FIFO with a pop on the stop-sample edge of the ninth byte
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) drive_frame(8'h10 + 8'(i), 1, 1, 0);
    pop_log.delete();
    e0 = cyc;
    fork
      drive_frame(8'h18, 1, 1, 0);
      begin
        while (cyc != e0 + LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    idle(3);
    check("t6_count", count, 8);
    check("t6_overflow", ovf, 0);
    check("t6_pops", pop_log.size(), 1);
    if (pop_log.size() > 0) check("t6_popped", pop_log[0], 8'h10);
    check("t6_head", data, 8'h11);
    ready = 1'b1;
    idle(12);

`ifdef TB_UART_RX_PARITY_EN
    // Parity mismatch drops the byte; correct parity passes it
    p0 = perr_cnt;
    pop_log.delete();
    drive_frame(8'h01, 0, 1, 0);
    idle(5);
    check("t7_perr_pulses", perr_cnt - p0, 1);
    check("t7_no_push", pop_log.size(), 0);
    drive_frame(8'h01, 1, 1, 0);
    idle(5);
    check("t7_push", pop_log.size(), 1);
    if (pop_log.size() > 0) check("t7_data", pop_log[0], 8'h01);
`else
    p0 = perr_cnt;
`endif
    check("perr_total", perr_cnt - p0, 0 + (p0 - p0 + (perr_cnt - p0 == 0 ? 0 : 0)));

    // Randomized frames with a randomly throttled consumer
    rnd_done = 0;
    fork
      begin
        while (!rnd_done) begin
          @(negedge clk);
          ready = ($urandom_range(0, 99) < ready_pct);
        end
      end
      begin
        for (int n = 0; n < 40; n++) begin
          case ($urandom_range(0, 2))
            0: ready_pct = 0;
            1: ready_pct = 30;
            default: ready_pct = 90;
          endcase
          k = $urandom_range(0, 9);
          if (k == 0) begin
            glitch($urandom_range(1, 6));
            idle(12);
          end else if (k == 1) begin
            drive_frame(8'($urandom), 1, 0, $urandom_range(0, 40));
            idle($urandom_range(4, 10));
          end else if (k == 2) begin
`ifdef TB_UART_RX_PARITY_EN
            drive_frame(8'($urandom), 0, 1, 0);
`else
            drive_frame(8'($urandom), 1, 1, 0);
`endif
            idle($urandom_range(0, 5));
          end else begin
            drive_frame(8'($urandom), 1, 1, 0);
            idle($urandom_range(0, 5));
          end
        end
        ready_pct = 100;
        idle(DEPTH * 2 + 5);
        rnd_done = 1;
      end
    join
    check("final_count", count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
